// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg -- shared Wishbone definitions
//
// Holds the bus address/data width constants, the matching vector types and
// the master FSM state enumeration. The slave blocks reuse the same package.
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  typedef logic [WB_ADDR_W-1:0] wb_addr_t;
  typedef logic [WB_DATA_W-1:0] wb_data_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_mem_master_if.sv
// -----------------------------------------------------------------------------
// wb_mem_master_if -- Wishbone pipelined-mode bus between master and slave
//
// Signals (named from the master's point of view):
//   o_wb_cyc, o_wb_stb, o_wb_we  master controls
//   o_wb_addr, o_wb_data         address and write data (32 bits each)
//   i_wb_ack, i_wb_stall, i_wb_err  slave responses
//   i_wb_data                    read data (32 bits)
// Modports: master (drives o_*), slave (drives i_*).
// -----------------------------------------------------------------------------
interface wb_mem_master_if;

  logic             o_wb_cyc;
  logic             o_wb_stb;
  logic             o_wb_we;
  wb_pkg::wb_addr_t o_wb_addr;
  wb_pkg::wb_data_t o_wb_data;
  logic             i_wb_ack;
  logic             i_wb_stall;
  logic             i_wb_err;
  wb_pkg::wb_data_t i_wb_data;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    input  i_wb_ack, i_wb_stall, i_wb_err, i_wb_data
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    output i_wb_ack, i_wb_stall, i_wb_err, i_wb_data
  );

endinterface

// File: rtl/wb_mem_master_timeout.sv
// -----------------------------------------------------------------------------
// wb_timeout -- response watchdog for wb_mem_master
//
// Counts rising edges while i_run is high and flags o_expired once
// TIMEOUT_CYCLES edges have elapsed since i_run first rose. Dropping i_run
// clears the count, so the master only has to hold i_run for the duration of
// the bus transfer. Only instantiated when WB_MASTER_TIMEOUT_EN is defined.
//
// Ports:
//   i_clk      clock
//   i_reset    asynchronous active-high reset (clears the count)
//   i_run      transfer in flight and strobe accepted
//   o_expired  limit reached in the current cycle (combinational)
// -----------------------------------------------------------------------------
module wb_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (!i_run) begin
      cnt_q <= '0;
    end else if (cnt_q != LIMIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_expired = i_run && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_mem_master.sv
// -----------------------------------------------------------------------------
// wb_mem_master -- single-outstanding Wishbone (pipelined mode) memory master
//
// Turns one requester transfer at a time into a Wishbone cycle and returns a
// one-cycle completion pulse with read data and an error flag.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_req_valid/we/addr/data  requester transfer (accepted when o_req_ready)
//   o_req_ready           high exactly while idle (pure state decode)
//   o_rsp_valid/data/err  completion pulse, read data, bus error or timeout
//   wb                    Wishbone master modport (wb_mem_master_if)
//
// Build option:
//   WB_MASTER_TIMEOUT_EN  when defined, a wb_timeout watchdog ends a transfer
//                         with an error after TIMEOUT_CYCLES cycles without
//                         ack/err. When undefined the master waits forever.
// -----------------------------------------------------------------------------
module wb_mem_master
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_req_valid,
  input  logic               i_req_we,
  input  wb_addr_t           i_req_addr,
  input  wb_data_t           i_req_data,
  output logic               o_req_ready,
  output logic               o_rsp_valid,
  output wb_data_t           o_rsp_data,
  output logic               o_rsp_err,
  wb_mem_master_if.master    wb
);

  wb_state_e state_q, state_d;

  logic accept;      // request taken from the requester this cycle
  logic stb_done;    // strobe accepted by the slave this cycle
  logic finish;      // transfer ends at this edge
  logic finish_err;  // ending transfer reports an error
  logic term;        // slave terminates the cycle
  logic expired;

  assign term = wb.i_wb_ack | wb.i_wb_err;

`ifdef WB_MASTER_TIMEOUT_EN
  logic tmo_run;

  // The watchdog starts on the edge the strobe is accepted and keeps running
  // while waiting for the slave's response.
  assign tmo_run = ((state_q == ST_STROBE) && !wb.i_wb_stall) ||
                   (state_q == ST_WAIT);

  wb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_run     (tmo_run),
    .o_expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // Ready is decoded from the state register only, so there is no
  // combinational path from the Wishbone inputs to the requester.
  assign o_req_ready = (state_q == ST_IDLE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    stb_done   = 1'b0;
    finish     = 1'b0;
    finish_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // ack/err arriving here belong to no cycle of ours and are ignored.
        if (i_req_valid) begin
          accept  = 1'b1;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (!wb.i_wb_stall) begin
          stb_done = 1'b1;
          if (term) begin
            // Zero-wait slave: acknowledged together with the strobe.
            finish     = 1'b1;
            finish_err = wb.i_wb_err;
            state_d    = ST_IDLE;
          end else if (expired) begin
            finish     = 1'b1;
            finish_err = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (term) begin
          finish     = 1'b1;
          finish_err = wb.i_wb_err;
          state_d    = ST_IDLE;
        end else if (expired) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- registered bus controls and response ----
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wb.o_wb_cyc  <= 1'b0;
      wb.o_wb_stb  <= 1'b0;
      wb.o_wb_we   <= 1'b0;
      wb.o_wb_addr <= '0;
      wb.o_wb_data <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_err    <= 1'b0;
      o_rsp_data   <= '0;
    end else begin
      o_rsp_valid <= finish;
      o_rsp_err   <= finish & finish_err;
      if (accept) begin
        wb.o_wb_cyc  <= 1'b1;
        wb.o_wb_stb  <= 1'b1;
        wb.o_wb_we   <= i_req_we;
        wb.o_wb_addr <= i_req_addr;
        wb.o_wb_data <= i_req_data;
      end
      if (stb_done || finish) begin
        wb.o_wb_stb <= 1'b0;
      end
      if (finish) begin
        wb.o_wb_cyc <= 1'b0;
      end
      // Read data is taken on the ack cycle and held until the next read.
      if (finish && !wb.o_wb_we && wb.i_wb_ack) begin
        o_rsp_data <= wb.i_wb_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_master.sv
// -----------------------------------------------------------------------------
// tb_wb_mem_master -- self-checking bench for wb_mem_master
//
// A scripted reactive slave answers the master. A transfer-level model of the
// master's observable behaviour is evaluated on every falling edge and the
// DUT outputs are compared against it; the stimulus also checks a set of
// hand-computed latencies and values.
// -----------------------------------------------------------------------------
module tb_wb_mem_master;
  import wb_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_data;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_data;

  wb_mem_master_if bus ();

  wb_mem_master #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err),
    .wb          (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scripted slave ----------------
  int          cfg_stall = 0;   // stall cycles before taking the strobe
  int          cfg_wait  = 0;   // 0: answer with the strobe; k: answer in k-th wait cycle
  bit          cfg_ack   = 1;
  bit          cfg_err   = 0;
  bit          cfg_spur  = 0;   // drive ack+err while no cycle is open
  logic [31:0] cfg_rdata = '0;
  int          stall_left, wait_left;
  logic [31:0] junk = 32'hBAD0_0000;

  task automatic slave_term();
    bus.i_wb_ack  = cfg_ack;
    bus.i_wb_err  = cfg_err;
    bus.i_wb_data = cfg_rdata;
  endtask

  always @(posedge clk) begin
    #1;
    junk           = junk + 32'h11;
    bus.i_wb_ack   = 1'b0;
    bus.i_wb_err   = 1'b0;
    bus.i_wb_stall = 1'b0;
    bus.i_wb_data  = junk;
    if (!bus.o_wb_cyc) begin
      stall_left = cfg_stall;
      wait_left  = 0;
      if (cfg_spur) begin
        bus.i_wb_ack = 1'b1;
        bus.i_wb_err = 1'b1;
      end
    end else if (bus.o_wb_stb) begin
      if (stall_left > 0) begin
        bus.i_wb_stall = 1'b1;
        stall_left--;
      end else if (cfg_wait == 0) begin
        slave_term();
      end else begin
        wait_left = cfg_wait;
      end
    end else if (wait_left > 0) begin
      wait_left--;
      if (wait_left == 0) slave_term();
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  bit          m_busy, m_strb, m_we, m_term, m_ends, m_tmo;
  logic [31:0] m_addr, m_data, m_rdata;
  int          m_cnt;
  bit          e_rv, e_re;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_strb = 0; m_we = 0;
      m_addr = '0; m_data = '0; m_rdata = '0;
      e_rv = 0; e_re = 0; m_cnt = 0;
    end
    chk("cyc",       bus.o_wb_cyc, m_busy);
    chk("stb",       bus.o_wb_stb, m_busy && m_strb);
    chk("req_ready", req_ready,    !m_busy);
    chk("rsp_valid", rsp_valid,    e_rv);
    chk("rsp_err",   rsp_err,      e_re);
    chk("rsp_data",  rsp_data,     m_rdata);
    chk("wb_data",   bus.o_wb_data, m_data);
    if (m_busy && m_strb) begin
      chk("wb_addr", bus.o_wb_addr, m_addr);
      chk("wb_we",   bus.o_wb_we,   m_we);
    end
    if (!rst) begin
      e_rv = 0;
      e_re = 0;
      if (!m_busy) begin
        if (req_valid) begin
          m_busy = 1; m_strb = 1;
          m_we = req_we; m_addr = req_addr; m_data = req_data;
        end
      end else begin
        m_term = bus.i_wb_ack || bus.i_wb_err;
        m_ends = 0;
        m_tmo  = 0;
        if (m_strb) begin
          if (!bus.i_wb_stall) begin
            m_strb = 0;
            m_cnt  = 0;        // edges counted from strobe acceptance
            m_ends = m_term;
          end
        end else begin
          m_cnt++;
          m_ends = m_term;
`ifdef WB_MASTER_TIMEOUT_EN
          if (!m_term && m_cnt == TO) m_tmo = 1;
`endif
        end
        if (m_ends || m_tmo) begin
          e_rv   = 1;
          e_re   = bus.i_wb_err || m_tmo;
          m_busy = 0;
          if (m_ends && !m_we && bus.i_wb_ack) m_rdata = bus.i_wb_data;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int          lat, st, cnt;
  logic        e;
  logic [31:0] rd;

  task automatic set_slave(input int stl, input int wt, input bit ack, input bit err,
                           input logic [31:0] rdat);
    @(negedge clk);
    cfg_stall = stl; cfg_wait = wt; cfg_ack = ack; cfg_err = err; cfg_rdata = rdat;
  endtask

  task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                      output int lat_o, output int st_o, output logic err_o,
                      output logic [31:0] rd_o);
    int g;
    g = 0;
    @(posedge clk); #1;
    while (!req_ready && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    if (!req_ready) begin
      n_vec++; n_bad++;
      $display("FAIL ready_wait: got 0 expected 1 within 20 cycles");
    end
    req_valid = 1'b1; req_we = we; req_addr = a; req_data = d;
    lat_o = 0; st_o = 0; err_o = 1'bx; rd_o = 'x;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat_o = 1;
    if (bus.o_wb_stb) st_o++;
    while (!rsp_valid && lat_o < 40) begin
      @(posedge clk); #1;
      lat_o++;
      if (bus.o_wb_stb) st_o++;
    end
    if (rsp_valid) begin
      err_o = rsp_err;
      rd_o  = rsp_data;
    end else begin
      n_vec++; n_bad++;
      $display("FAIL rsp_wait: got no response expected one within 40 cycles");
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready",    req_ready, 1);
    chk("reset_cyc",      bus.o_wb_cyc, 0);
    chk("reset_rsp_data", rsp_data, 0);

    // zero-wait write
    set_slave(0, 0, 1, 0, 32'h0);
    xfer(1'b1, 32'h10, 32'hDEADBEEF, lat, st, e, rd);
    chk("wr_latency", lat, 2);
    chk("wr_stb_cycles", st, 1);
    chk("wr_err", e, 0);

    // zero-wait read of the same location
    set_slave(0, 0, 1, 0, 32'hDEADBEEF);
    xfer(1'b0, 32'h10, 32'h0, lat, st, e, rd);
    chk("rd_latency", lat, 2);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", e, 0);

    // three stall cycles then zero-wait ack
    set_slave(3, 0, 1, 0, 32'h0);
    xfer(1'b1, 32'h24, 32'h12345678, lat, st, e, rd);
    chk("stall_stb_cycles", st, 4);
    chk("stall_latency", lat, 5);
    chk("stall_data_held", rd, 32'hDEADBEEF);

    // read with two wait cycles
    set_slave(0, 2, 1, 0, 32'hCAFEF00D);
    xfer(1'b0, 32'h30, 32'h0, lat, st, e, rd);
    chk("wait_latency", lat, 4);
    chk("wait_rd_data", rd, 32'hCAFEF00D);

    // bus error in the wait phase
    set_slave(0, 1, 0, 1, 32'h0);
    xfer(1'b0, 32'h34, 32'h0, lat, st, e, rd);
    chk("err_latency", lat, 3);
    chk("err_flag", e, 1);

    // ack and err together in the wait phase
    set_slave(0, 1, 1, 1, 32'h55AA55AA);
    xfer(1'b0, 32'h38, 32'h0, lat, st, e, rd);
    chk("ackerr_flag", e, 1);

    // ack and err together with the strobe
    set_slave(0, 0, 1, 1, 32'h0);
    xfer(1'b1, 32'h3C, 32'hA5A5A5A5, lat, st, e, rd);
    chk("ackerr0_latency", lat, 2);
    chk("ackerr0_flag", e, 1);

    // stray ack/err while no cycle is open must be ignored
    @(negedge clk); cfg_spur = 1;
    cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid) cnt++;
    end
    @(negedge clk); cfg_spur = 0;
    chk("spurious_rsp", cnt, 0);

    // slave that never answers
    set_slave(0, 0, 0, 0, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_data = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
`ifdef WB_MASTER_TIMEOUT_EN
    chk("timeout_latency", lat, 10);
    chk("timeout_err", rsp_err, 1);
    chk("timeout_cyc", bus.o_wb_cyc, 0);
`else
    chk("hang_no_rsp", rsp_valid, 0);
    chk("hang_cyc", bus.o_wb_cyc, 1);
`endif
    // reset clears any hung cycle
    #2 rst = 1'b1;
    #1 chk("hang_rst_cyc", bus.o_wb_cyc, 0);
    @(posedge clk); #1 rst = 1'b0;

    // reset between edges while waiting for the slave
    set_slave(0, 6, 1, 0, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h50; req_data = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_wait_cyc",   bus.o_wb_cyc, 0);
    chk("rst_wait_stb",   bus.o_wb_stb, 0);
    chk("rst_wait_rsp",   rsp_valid, 0);
    chk("rst_wait_data",  bus.o_wb_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_release_ready", req_ready, 1);
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid) cnt++;
    end
    chk("rst_no_rsp", cnt, 0);

    // normal operation after reset
    set_slave(0, 0, 1, 0, 32'h0);
    xfer(1'b1, 32'h44, 32'h0BADF00D, lat, st, e, rd);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_err", e, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
